load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory-access stage that sits directly upstream of the byte-addressed data memory.
- Accepts load/store requests from execute over a valid/ready handshake and decodes RV32I funct3.
- Drives the memory's WE/Size/ADDR/WD port and captures its combinational read data.
- Splits misaligned half-word/word accesses into sequential byte accesses, checks address range, and returns extended load data or an error over a valid/ready response handshake.

Parameters:
ADDR_WIDTH, 32, request/memory address width
MEM_BYTES, 256, data memory size in bytes; valid addresses are 0..MEM_BYTES-1
SPLIT_MISALIGNED, 1, 1 = split misaligned accesses into byte accesses; 0 = report a misaligned error

Ports:
clk  in  1  clock; everything is on the rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  1  request valid
req_ready  out  1  request accepted when req_valid && req_ready
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  RV32I funct3 (LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101)
req_addr  in  ADDR_WIDTH  byte address
req_wdata  in  32  store data, LSB-aligned
resp_valid  out  1  response valid
resp_ready  in  1  response consumed when resp_valid && resp_ready
resp_rdata  out  32  extended load data; 0 for stores and errors
resp_err  out  1  request faulted; no memory access was made
resp_err_code  out  2  00 none, 01 illegal funct3, 10 misaligned, 11 out of range
mem_we  out  1  memory write enable
mem_size  out  3  000 word, 001 signed half, 010 unsigned half, 011 signed byte, 100 unsigned byte
mem_addr  out  ADDR_WIDTH  memory address
mem_wd  out  32  memory write data
mem_rd  in  32  memory read data (combinational from mem_addr/mem_size)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - state IDLE, so req_ready=1 from the first post-reset cycle.
  - resp_valid=0, resp_rdata=0, resp_err=0, resp_err_code=00.
  - mem_we=0, mem_size=000, mem_addr=0, mem_wd=0.
- Memory outputs are driven only in ACCESS/SPLIT; they are zero in all other states.
- States: IDLE, ACCESS, SPLIT, RESP.
- IDLE:
  - req_ready=1.
  - On handshake, latch we/funct3/addr/wdata and compute nbytes (1/2/4).
  - Illegal funct3 (011, 110, 111, or 100/101 with req_we=1): go to RESP with err 01.
  - addr+nbytes-1 >= MEM_BYTES, computed without wrap in ADDR_WIDTH+1 bits: go to RESP with err 11.
  - Misaligned (half with addr[0]=1, word with addr[1:0]!=0): go to SPLIT if SPLIT_MISALIGNED, else RESP with err 10.
  - Otherwise go to ACCESS.
  - Error priority: 01 > 11 > 10.
- ACCESS (exactly 1 cycle):
  - mem_addr=addr.
  - Store: mem_size = 000 (SW) / 001 (SH) / 011 (SB), mem_wd=wdata, mem_we=1.
  - Load: mem_size = 000 (LW) / 001 (LH) / 010 (LHU) / 011 (LB) / 100 (LBU), mem_we=0.
  - Capture mem_rd into resp_rdata at the end of the cycle, then go to RESP.
- SPLIT:
  - Byte counter k = 0..nbytes-1, one byte per cycle, mem_addr=addr+k.
  - Store: mem_size=011, mem_wd={24'b0, wdata[8k+7:8k]}, mem_we=1.
  - Load: mem_size=100, mem_we=0; mem_rd[7:0] is captured into byte lane k of an accumulator (little-endian).
  - After the last byte, sign- or zero-extend the accumulator per funct3 into resp_rdata and go to RESP.
- RESP:
  - resp_valid=1, req_ready=0.
  - resp_rdata/resp_err/resp_err_code hold stable until resp_ready.
  - On handshake go to IDLE; a new request is accepted no earlier than the following cycle (no bypass).
- Latency (request accepted at edge N):
  - Aligned: memory driven in cycle N+1, resp_valid from edge N+2.
  - Split: memory driven in cycles N+1..N+nbytes, resp_valid from edge N+nbytes+1.
  - Errors: resp_valid from edge N+1, with no memory cycle.
- Stores respond with resp_rdata=0.
- req_ready=0 in every state except IDLE.
- Reset mid-operation:
  - Reset wins immediately and the transaction is dropped with no response.
  - Bytes already written by a split store remain in memory; this is accepted architectural behaviour.
- Input changes while not in IDLE are ignored, because the request is latched.

Decomposition:
- Shared package lsu_pkg:
  - funct3 constants.
  - Memory size encodings MEM_WORD/MEM_HALF_S/MEM_HALF_U/MEM_BYTE_S/MEM_BYTE_U.
  - Error codes.
  - State enum.
- One natural sub-module, load_extend: combinational; takes funct3 and a raw 32-bit value and returns the sign/zero-extended result. It is used on the split path.

Test Plan:
- Preload mem[0x10..0x13]=0D,F0,AD,8B; LW at 0x10 -> mem_size=000 for one cycle, resp_valid 2 cycles after accept, rdata=0x8BADF00D, err=0.
- Preload mem[0x13]=0x80, mem[0x14]=0xFF; LH at 0x13 -> two SPLIT cycles (addr 0x13, 0x14, size 100), rdata=0xFFFFFF80. LHU at the same address -> 0x0000FF80.
- SW 0xA1B2C3D4 at 0x21 -> four byte writes mem[0x21..0x24]=D4,C3,B2,A1; then LBU 0x24 -> 0x000000A1 and LB 0x22 -> 0xFFFFFFC3.
- Out of range: LW at 0xFE -> err code 11, rdata=0, mem_we never asserted. Illegal funct3: SB with funct3=100 -> err code 01.
- Backpressure: hold resp_ready=0 for 5 cycles after an LW -> resp_valid stays high, rdata stable, req_ready=0, a new req_valid is not accepted. With SPLIT_MISALIGNED=0, LW at 0x02 -> err code 10.
- Assert rst during byte 2 of a split SW at 0x31 -> next cycle in IDLE with req_ready=1, resp_valid=0, mem_we=0; bytes 0x31..0x32 are written, 0x33..0x34 are unchanged.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, memory
// size encodings, error codes, FSM states and small decode helpers.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [2:0] MEM_WORD   = 3'b000;
    localparam logic [2:0] MEM_HALF_S = 3'b001;
    localparam logic [2:0] MEM_HALF_U = 3'b010;
    localparam logic [2:0] MEM_BYTE_S = 3'b011;
    localparam logic [2:0] MEM_BYTE_U = 3'b100;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_FUNCT3   = 2'b01;
    localparam logic [1:0] ERR_MISALIGN = 2'b10;
    localparam logic [1:0] ERR_RANGE    = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_SPLIT,
        S_RESP
    } lsu_state_e;

    // Index of the last byte of the access: 0 byte, 1 half, 3 word.
    function automatic logic [1:0] f3_klast(input logic [2:0] f3);
        logic [1:0] k;
        k = 2'd0;
        case (f3)
            F3_H, F3_HU: k = 2'd1;
            F3_W:        k = 2'd3;
            default:     k = 2'd0;
        endcase
        return k;
    endfunction

    // Memory port size code for an aligned access of this funct3.
    function automatic logic [2:0] f3_mem_size(input logic [2:0] f3);
        logic [2:0] s;
        s = MEM_WORD;
        case (f3)
            F3_W:    s = MEM_WORD;
            F3_H:    s = MEM_HALF_S;
            F3_HU:   s = MEM_HALF_U;
            F3_B:    s = MEM_BYTE_S;
            F3_BU:   s = MEM_BYTE_U;
            default: s = MEM_WORD;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Sign/zero extension of raw load data according to RV32I funct3.
// Purely combinational; used on the split (byte-assembled) load path.
module load_extend
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] raw,
    output logic [31:0] ext
);

    // Select the extension rule for the load width and signedness.
    always_comb begin
        ext = raw;
        case (funct3)
            F3_B:    ext = {{24{raw[7]}}, raw[7:0]};
            F3_BU:   ext = {24'b0, raw[7:0]};
            F3_H:    ext = {{16{raw[15]}}, raw[15:0]};
            F3_HU:   ext = {16'b0, raw[15:0]};
            default: ext = raw;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: decodes load/store requests, drives the data
// memory port, splits misaligned accesses into bytes, returns responses.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH       = 32,
    parameter int MEM_BYTES        = 256,
    parameter bit SPLIT_MISALIGNED = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic [1:0]            resp_err_code,
    output logic                  mem_we,
    output logic [2:0]            mem_size,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wd,
    input  logic [31:0]           mem_rd
);

    localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH+1)'(MEM_BYTES);

    lsu_state_e            state_q;
    lsu_state_e            state_d;
    logic                  we_q;
    logic [2:0]            f3_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [1:0]            klast_q;
    logic [1:0]            k_q;
    logic [31:0]           acc_q;
    logic [31:0]           acc_d;
    logic [31:0]           acc_ext;

    logic [1:0]            req_klast;
    logic                  req_illegal;
    logic                  req_misal;
    logic                  req_range;
    logic [ADDR_WIDTH:0]   req_last;
    logic [1:0]            req_code;

    assign req_klast = f3_klast(req_funct3);

    // Classify the incoming request; the last byte address is formed
    // one bit wider so an access near the top of the space cannot wrap.
    always_comb begin
        req_illegal = 1'b0;
        case (req_funct3)
            F3_B, F3_H, F3_W: req_illegal = 1'b0;
            F3_BU, F3_HU:     req_illegal = req_we;
            default:          req_illegal = 1'b1;
        endcase
        req_last  = {1'b0, req_addr}
                  + {{(ADDR_WIDTH-1){1'b0}}, req_klast};
        req_range = (req_last >= MEM_LIMIT);
        req_misal = ((req_klast == 2'd1) && req_addr[0])
                 || ((req_klast == 2'd3) && (req_addr[1:0] != 2'b00));
        req_code  = ERR_NONE;
        if (req_illegal) begin
            req_code = ERR_FUNCT3;
        end else if (req_range) begin
            req_code = ERR_RANGE;
        end else if (req_misal && !SPLIT_MISALIGNED) begin
            req_code = ERR_MISALIGN;
        end
    end

    // Merge the current memory byte into its lane of the accumulator.
    always_comb begin
        acc_d = acc_q;
        acc_d[{k_q, 3'b000} +: 8] = mem_rd[7:0];
    end

    load_extend u_ext (
        .funct3 (f3_q),
        .raw    (acc_d),
        .ext    (acc_ext)
    );

    // Next-state and handshake/memory port outputs; reset blanks the
    // memory port at once so an interrupted access writes nothing.
    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_we     = 1'b0;
        mem_size   = MEM_WORD;
        mem_addr   = '0;
        mem_wd     = '0;
        unique case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_code != ERR_NONE) begin
                        state_d = S_RESP;
                    end else if (req_misal) begin
                        state_d = S_SPLIT;
                    end else begin
                        state_d = S_ACCESS;
                    end
                end
            end
            S_ACCESS: begin
                mem_addr = addr_q;
                mem_size = f3_mem_size(f3_q);
                mem_we   = we_q;
                mem_wd   = we_q ? wdata_q : 32'b0;
                state_d  = S_RESP;
            end
            S_SPLIT: begin
                mem_addr = addr_q + {{(ADDR_WIDTH-2){1'b0}}, k_q};
                mem_size = we_q ? MEM_BYTE_S : MEM_BYTE_U;
                mem_we   = we_q;
                mem_wd   = we_q ? {24'b0, wdata_q[{k_q, 3'b000} +: 8]}
                                : 32'b0;
                if (k_q == klast_q) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (rst) begin
            mem_we   = 1'b0;
            mem_size = MEM_WORD;
            mem_addr = '0;
            mem_wd   = '0;
        end
    end

    // State register, request latch, byte counter and response data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            we_q          <= 1'b0;
            f3_q          <= F3_B;
            addr_q        <= '0;
            wdata_q       <= '0;
            klast_q       <= 2'd0;
            k_q           <= 2'd0;
            acc_q         <= '0;
            resp_rdata    <= '0;
            resp_err      <= 1'b0;
            resp_err_code <= ERR_NONE;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        we_q          <= req_we;
                        f3_q          <= req_funct3;
                        addr_q        <= req_addr;
                        wdata_q       <= req_wdata;
                        klast_q       <= req_klast;
                        k_q           <= 2'd0;
                        acc_q         <= '0;
                        resp_rdata    <= '0;
                        resp_err      <= (req_code != ERR_NONE);
                        resp_err_code <= req_code;
                    end
                end
                S_ACCESS: begin
                    resp_rdata <= we_q ? 32'b0 : mem_rd;
                end
                S_SPLIT: begin
                    k_q <= k_q + 2'd1;
                    if (!we_q) begin
                        acc_q <= acc_d;
                    end
                    if (k_q == klast_q) begin
                        resp_rdata <= we_q ? 32'b0 : acc_ext;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_rdata    <= '0;
                        resp_err      <= 1'b0;
                        resp_err_code <= ERR_NONE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte-addressed memory model
// and a second instance built without misaligned splitting.
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [1:0]  resp_err_code;
    logic        mem_we;
    logic [2:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    logic        r2_valid;
    logic        r2_ready;
    logic        r2_we;
    logic [2:0]  r2_funct3;
    logic [31:0] r2_addr;
    logic [31:0] r2_wdata;
    logic        p2_valid;
    logic        p2_ready;
    logic [31:0] p2_rdata;
    logic        p2_err;
    logic [1:0]  p2_code;
    logic        m2_we;
    logic [2:0]  m2_size;
    logic [31:0] m2_addr;
    logic [31:0] m2_wd;
    logic [31:0] m2_rd;

    int nvec = 0;
    int nerr = 0;

    logic [7:0]  mem [0:255];
    logic        pl_we;
    logic [7:0]  pl_addr;
    logic [7:0]  pl_data;
    logic [7:0]  ma;
    logic [7:0]  b0, b1, b2, b3;

    int          x_lat;
    logic [31:0] x_rd;
    logic        x_err;
    logic [1:0]  x_code;
    int          nmem;
    int          nwe;
    logic [31:0] maddr [8];
    logic [2:0]  msize [8];

    load_store_unit u_dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_funct3    (req_funct3),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_rdata    (resp_rdata),
        .resp_err      (resp_err),
        .resp_err_code (resp_err_code),
        .mem_we        (mem_we),
        .mem_size      (mem_size),
        .mem_addr      (mem_addr),
        .mem_wd        (mem_wd),
        .mem_rd        (mem_rd)
    );

    load_store_unit #(.SPLIT_MISALIGNED(1'b0)) u_ns (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (r2_valid),
        .req_ready     (r2_ready),
        .req_we        (r2_we),
        .req_funct3    (r2_funct3),
        .req_addr      (r2_addr),
        .req_wdata     (r2_wdata),
        .resp_valid    (p2_valid),
        .resp_ready    (p2_ready),
        .resp_rdata    (p2_rdata),
        .resp_err      (p2_err),
        .resp_err_code (p2_code),
        .mem_we        (m2_we),
        .mem_size      (m2_size),
        .mem_addr      (m2_addr),
        .mem_wd        (m2_wd),
        .mem_rd        (m2_rd)
    );

    assign m2_rd = 32'h0;
    assign ma    = mem_addr[7:0];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: preload port has priority over DUT writes.
    always @(posedge clk) begin
        if (pl_we) begin
            mem[pl_addr] <= pl_data;
        end else if (mem_we) begin
            case (mem_size)
                3'b000: begin
                    mem[ma]        <= mem_wd[7:0];
                    mem[ma + 8'd1] <= mem_wd[15:8];
                    mem[ma + 8'd2] <= mem_wd[23:16];
                    mem[ma + 8'd3] <= mem_wd[31:24];
                end
                3'b001: begin
                    mem[ma]        <= mem_wd[7:0];
                    mem[ma + 8'd1] <= mem_wd[15:8];
                end
                default: mem[ma] <= mem_wd[7:0];
            endcase
        end
    end

    // Combinational read with size-dependent extension.
    always_comb begin
        b0 = mem[ma];
        b1 = mem[ma + 8'd1];
        b2 = mem[ma + 8'd2];
        b3 = mem[ma + 8'd3];
        case (mem_size)
            3'b000:  mem_rd = {b3, b2, b1, b0};
            3'b001:  mem_rd = {{16{b1[7]}}, b1, b0};
            3'b010:  mem_rd = {16'b0, b1, b0};
            3'b011:  mem_rd = {{24{b0[7]}}, b0};
            3'b100:  mem_rd = {24'b0, b0};
            default: mem_rd = 32'h0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        pl_we   = 1'b1;
        pl_addr = a;
        pl_data = d;
        @(posedge clk); #1;
        pl_we   = 1'b0;
    endtask

    // One request/response; hold>0 stalls resp_ready while a second
    // request is offered, checking that the response stays put.
    task automatic xact(input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int hold);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_addr  = 32'hFFFF_FFFF;
        req_wdata = 32'hFFFF_FFFF;
        x_lat = 1;
        nmem  = 0;
        nwe   = 0;
        while (!resp_valid && x_lat < 12) begin
            if (nmem < 8) begin
                maddr[nmem] = mem_addr;
                msize[nmem] = mem_size;
            end
            nmem++;
            if (mem_we) nwe++;
            @(posedge clk); #1;
            x_lat++;
        end
        chk("resp_valid_seen", 32'(resp_valid), 32'd1);
        x_rd   = resp_rdata;
        x_err  = resp_err;
        x_code = resp_err_code;
        if (hold > 0) begin
            req_valid  = 1'b1;
            req_we     = 1'b0;
            req_funct3 = 3'b100;
            req_addr   = 32'h24;
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", 32'(resp_valid), 32'd1);
            chk("hold_rdata", resp_rdata, x_rd);
            chk("hold_req_ready", 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        req_valid  = 1'b0;
        chk("back_idle_ready", 32'(req_ready), 32'd1);
        chk("back_idle_valid", 32'(resp_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        resp_ready = 1'b0;
        r2_valid   = 1'b0;
        r2_we      = 1'b0;
        r2_funct3  = 3'b010;
        r2_addr    = 32'h0;
        r2_wdata   = 32'h0;
        p2_ready   = 1'b0;
        pl_we      = 1'b0;
        pl_addr    = 8'h0;
        pl_data    = 8'h0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_err", {29'b0, resp_err, resp_err_code}, 32'h0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_size", 32'(mem_size), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wd", mem_wd, 32'h0);

        preload(8'h10, 8'h0D);
        preload(8'h11, 8'hF0);
        preload(8'h12, 8'hAD);
        preload(8'h13, 8'h8B);
        xact(1'b0, 3'b010, 32'h10, 32'h0, 0);
        chk("lw_lat", 32'(x_lat), 32'd2);
        chk("lw_size", 32'(msize[0]), 32'h0);
        chk("lw_addr", maddr[0], 32'h10);
        chk("lw_rdata", x_rd, 32'h8BAD_F00D);
        chk("lw_err", {29'b0, x_err, x_code}, 32'h0);

        preload(8'h13, 8'h80);
        preload(8'h14, 8'hFF);
        xact(1'b0, 3'b001, 32'h13, 32'h0, 0);
        chk("lh_lat", 32'(x_lat), 32'd3);
        chk("lh_addr0", maddr[0], 32'h13);
        chk("lh_addr1", maddr[1], 32'h14);
        chk("lh_size0", 32'(msize[0]), 32'h4);
        chk("lh_size1", 32'(msize[1]), 32'h4);
        chk("lh_rdata", x_rd, 32'hFFFF_FF80);
        xact(1'b0, 3'b101, 32'h13, 32'h0, 0);
        chk("lhu_rdata", x_rd, 32'h0000_FF80);

        xact(1'b1, 3'b010, 32'h21, 32'hA1B2_C3D4, 0);
        chk("sw_split_lat", 32'(x_lat), 32'd5);
        chk("sw_split_nwe", 32'(nwe), 32'd4);
        chk("sw_split_size", 32'(msize[3]), 32'h3);
        chk("sw_split_rdata", x_rd, 32'h0);
        chk("sw_mem21", 32'(mem[8'h21]), 32'hD4);
        chk("sw_mem22", 32'(mem[8'h22]), 32'hC3);
        chk("sw_mem23", 32'(mem[8'h23]), 32'hB2);
        chk("sw_mem24", 32'(mem[8'h24]), 32'hA1);
        xact(1'b0, 3'b100, 32'h24, 32'h0, 0);
        chk("lbu_lat", 32'(x_lat), 32'd2);
        chk("lbu_rdata", x_rd, 32'h0000_00A1);
        xact(1'b0, 3'b000, 32'h22, 32'h0, 0);
        chk("lb_rdata", x_rd, 32'hFFFF_FFC3);

        xact(1'b0, 3'b010, 32'hFE, 32'h0, 0);
        chk("oor_code", {29'b0, x_err, x_code}, 32'h7);
        chk("oor_rdata", x_rd, 32'h0);
        chk("oor_lat", 32'(x_lat), 32'd1);
        chk("oor_nwe", 32'(nwe), 32'd0);
        xact(1'b1, 3'b100, 32'h40, 32'h55, 0);
        chk("ill_sb_code", {29'b0, x_err, x_code}, 32'h5);
        chk("ill_sb_nwe", 32'(nwe), 32'd0);
        xact(1'b0, 3'b111, 32'hFF, 32'h0, 0);
        chk("ill_over_oor", {29'b0, x_err, x_code}, 32'h5);
        xact(1'b0, 3'b001, 32'hFF, 32'h0, 0);
        chk("oor_over_mis", {29'b0, x_err, x_code}, 32'h7);
        xact(1'b0, 3'b010, 32'hFFFF_FFFE, 32'h0, 0);
        chk("oor_nowrap", {29'b0, x_err, x_code}, 32'h7);
        preload(8'hFF, 8'h5A);
        xact(1'b0, 3'b100, 32'hFF, 32'h0, 0);
        chk("top_byte_err", {29'b0, x_err, x_code}, 32'h0);
        chk("top_byte_rdata", x_rd, 32'h0000_005A);

        xact(1'b0, 3'b010, 32'h10, 32'h0, 5);
        chk("bp_rdata", x_rd, 32'h80AD_F00D);

        r2_valid  = 1'b1;
        r2_funct3 = 3'b010;
        r2_addr   = 32'h02;
        chk("ns_req_ready", 32'(r2_ready), 32'd1);
        @(posedge clk); #1;
        r2_valid = 1'b0;
        chk("ns_resp_valid", 32'(p2_valid), 32'd1);
        chk("ns_mis_code", {29'b0, p2_err, p2_code}, 32'h6);
        chk("ns_rdata", p2_rdata, 32'h0);
        chk("ns_mem_we", 32'(m2_we), 32'd0);
        chk("ns_mem_port", m2_addr | m2_wd | 32'(m2_size), 32'h0);
        p2_ready = 1'b1;
        @(posedge clk); #1;
        p2_ready = 1'b0;
        chk("ns_done", 32'(p2_valid), 32'd0);

        preload(8'h31, 8'h11);
        preload(8'h32, 8'h22);
        preload(8'h33, 8'h33);
        preload(8'h34, 8'h44);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h31;
        req_wdata  = 32'hA5B6_C7D8;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_split_addr", mem_addr, 32'h33);
        rst = 1'b1;
        #1;
        chk("rst_gate_we", 32'(mem_we), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_mid_ready", 32'(req_ready), 32'd1);
        chk("rst_mid_valid", 32'(resp_valid), 32'd0);
        chk("rst_mid_we", 32'(mem_we), 32'd0);
        chk("rst_mem31", 32'(mem[8'h31]), 32'hD8);
        chk("rst_mem32", 32'(mem[8'h32]), 32'hC7);
        chk("rst_mem33", 32'(mem[8'h33]), 32'h33);
        chk("rst_mem34", 32'(mem[8'h34]), 32'h44);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
